// File: rtl/cal_pkg.sv
// Shared calendar definitions for the month/year stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cal_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        SET_MONTH = 2'd1,
        SET_YEAR  = 2'd2
    } state_e;

    localparam int MONTH_W      = 4;
    localparam int MONTH_MIN    = 1;
    localparam int MONTH_MAX    = 12;
    localparam int YEAR_MAX_DEF = 99;

endpackage

// File: rtl/wrap_counter.sv
// Counts MIN..MAX on inc, wraps MAX->MIN, with a parallel load.
// Latency: new count one cycle after inc/load; wrap is combinational from inc.
// Backpressure: none; inc is honoured every cycle it is high.
//
// Ports:
//   clk, clear  clock and synchronous active-high reset (count -> MIN)
//   inc         advance by one
//   load        load load_val; wins over a same-cycle inc
//   load_val    value to load (caller guarantees MIN..MAX)
//   cnt         current count
//   wrap        high in the cycle an inc takes the count MAX->MIN
module wrap_counter #(
    parameter int W   = 4,
    parameter int MIN = 1,
    parameter int MAX = 12
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         at_max;

    assign at_max = (cnt_q == W'(MAX));

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (inc) begin
            cnt_d = at_max ? W'(MIN) : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            cnt_q <= W'(MIN);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign wrap = inc & ~load & at_max;

endmodule

// File: rtl/month_year_counter.sv
// Month (1..12) / year (0..YEAR_MAX) stage fed by the day counter's rollover pulse.
// Latency: month/year update one cycle after the advancing edge; databus is combinational.
// Backpressure: none; day_wraps arriving while being set collapse into one pending advance.
//
// Ports:
//   clk, clear       clock and synchronous active-high reset (dominates everything)
//   day_wrap         one-cycle pulse on the day counter's 30->1 rollover
//   set_req          starts the month-then-year set sequence from RUN
//   confirm, data    capture data into the field being set (out-of-range values rejected)
//   sel, enable      databus source select (0 month, 1 year) and output enable
//   month, year      current calendar values
//   databus          enable ? (sel ? year : month) : 0
//   busy             high while a set sequence is in progress
//   year_wrap        registered one-cycle pulse coinciding with year showing 0 after YEAR_MAX
module month_year_counter
    import cal_pkg::*;
#(
    parameter int YEAR_W   = 7,
    parameter int YEAR_MAX = YEAR_MAX_DEF
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              day_wrap,
    input  logic              set_req,
    input  logic              confirm,
    input  logic [YEAR_W-1:0] data,
    input  logic              sel,
    input  logic              enable,
    output logic [MONTH_W-1:0] month,
    output logic [YEAR_W-1:0] year,
    output logic [YEAR_W-1:0] databus,
    output logic              busy,
    output logic              year_wrap
);

    state_e state_q;
    state_e state_d;
    logic   pending_q;
    logic   pending_d;
    logic   year_wrap_q;
    logic   year_wrap_d;

    logic   advance;
    logic   month_ld;
    logic   year_ld;
    logic   month_wrap;
    logic   year_cnt_wrap;
    logic   month_ok;
    logic   year_ok;

    // Range checks use the full data width so non-zero upper bits reject a month.
    assign month_ok = (data >= YEAR_W'(MONTH_MIN)) && (data <= YEAR_W'(MONTH_MAX));
    assign year_ok  = (data <= YEAR_W'(YEAR_MAX));

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        advance   = 1'b0;
        month_ld  = 1'b0;
        year_ld   = 1'b0;

        unique case (state_q)
            RUN: begin
                if (set_req) begin
                    // Entering set mode freezes counting; a same-cycle day_wrap is kept.
                    state_d   = SET_MONTH;
                    pending_d = pending_q | day_wrap;
                end else begin
                    // One advance per cycle. If a stored wrap and a fresh one coincide,
                    // apply one now and keep the flag for the next cycle.
                    advance   = day_wrap | pending_q;
                    pending_d = day_wrap & pending_q;
                end
            end
            SET_MONTH: begin
                pending_d = pending_q | day_wrap;
                if (confirm && month_ok) begin
                    month_ld = 1'b1;
                    state_d  = SET_YEAR;
                end
            end
            SET_YEAR: begin
                pending_d = pending_q | day_wrap;
                if (confirm && year_ok) begin
                    year_ld = 1'b1;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        year_wrap_d = year_cnt_wrap;
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q     <= RUN;
            pending_q   <= 1'b0;
            year_wrap_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            year_wrap_q <= year_wrap_d;
        end
    end

    wrap_counter #(
        .W   (MONTH_W),
        .MIN (MONTH_MIN),
        .MAX (MONTH_MAX)
    ) u_month (
        .clk      (clk),
        .clear    (clear),
        .inc      (advance),
        .load     (month_ld),
        .load_val (data[MONTH_W-1:0]),
        .cnt      (month),
        .wrap     (month_wrap)
    );

    wrap_counter #(
        .W   (YEAR_W),
        .MIN (0),
        .MAX (YEAR_MAX)
    ) u_year (
        .clk      (clk),
        .clear    (clear),
        .inc      (month_wrap),
        .load     (year_ld),
        .load_val (data),
        .cnt      (year),
        .wrap     (year_cnt_wrap)
    );

    assign busy      = (state_q != RUN);
    assign year_wrap = year_wrap_q;
    assign databus   = enable ? (sel ? year : YEAR_W'(month)) : '0;

endmodule

// File: tb/tb_month_year_counter.sv
module tb_month_year_counter;

    localparam int YW = 7;

    logic          clk;
    logic          clear;
    logic          day_wrap;
    logic          set_req;
    logic          confirm;
    logic [YW-1:0] data;
    logic          sel;
    logic          enable;
    logic [3:0]    month;
    logic [YW-1:0] year;
    logic [YW-1:0] databus;
    logic          busy;
    logic          year_wrap;

    int checks;
    int failures;

    month_year_counter #(.YEAR_W(YW), .YEAR_MAX(99)) dut (
        .clk       (clk),
        .clear     (clear),
        .day_wrap  (day_wrap),
        .set_req   (set_req),
        .confirm   (confirm),
        .data      (data),
        .sel       (sel),
        .enable    (enable),
        .month     (month),
        .year      (year),
        .databus   (databus),
        .busy      (busy),
        .year_wrap (year_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_set_req();
        set_req = 1'b1;
        tick();
        set_req = 1'b0;
    endtask

    task automatic pulse_confirm(input logic [YW-1:0] v);
        data    = v;
        confirm = 1'b1;
        tick();
        confirm = 1'b0;
        data    = '0;
    endtask

    task automatic pulse_day_wrap();
        day_wrap = 1'b1;
        tick();
        day_wrap = 1'b0;
    endtask

    task automatic test_reset();
        clear = 1'b1;
        tick();
        tick();
        clear = 1'b0;
        checks++;
        if (month !== 4'd1) begin failures++; $display("FAIL reset_month got=%0d exp=1", month); end
        checks++;
        if (year !== 7'd0) begin failures++; $display("FAIL reset_year got=%0d exp=0", year); end
        checks++;
        if (busy !== 1'b0 || year_wrap !== 1'b0) begin
            failures++; $display("FAIL reset_flags got busy=%b year_wrap=%b exp=0/0", busy, year_wrap);
        end
        enable = 1'b1; sel = 1'b0; #1;
        checks++;
        if (databus !== 7'd1) begin failures++; $display("FAIL reset_databus got=%0d exp=1", databus); end
        enable = 1'b0;
    endtask

    task automatic test_advance();
        for (int i = 0; i < 11; i++) pulse_day_wrap();
        checks++;
        if (month !== 4'd12 || year !== 7'd0) begin
            failures++; $display("FAIL adv_11 got m=%0d y=%0d exp m=12 y=0", month, year);
        end
        pulse_day_wrap();
        checks++;
        if (month !== 4'd1 || year !== 7'd1 || year_wrap !== 1'b0) begin
            failures++; $display("FAIL adv_12 got m=%0d y=%0d yw=%b exp m=1 y=1 yw=0", month, year, year_wrap);
        end
    endtask

    task automatic test_year_wrap();
        pulse_set_req();
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL yw_busy got=%b exp=1", busy); end
        pulse_confirm(7'd12);
        pulse_confirm(7'd99);
        checks++;
        if (month !== 4'd12 || year !== 7'd99 || busy !== 1'b0) begin
            failures++; $display("FAIL yw_set got m=%0d y=%0d busy=%b exp m=12 y=99 busy=0", month, year, busy);
        end
        pulse_day_wrap();
        checks++;
        if (month !== 4'd1 || year !== 7'd0 || year_wrap !== 1'b1) begin
            failures++; $display("FAIL yw_wrap got m=%0d y=%0d yw=%b exp m=1 y=0 yw=1", month, year, year_wrap);
        end
        tick();
        checks++;
        if (year_wrap !== 1'b0) begin failures++; $display("FAIL yw_clear got=%b exp=0", year_wrap); end
    endtask

    task automatic test_set_rejects();
        pulse_set_req();
        pulse_confirm(7'd13);
        checks++;
        if (busy !== 1'b1 || month !== 4'd1) begin
            failures++; $display("FAIL rej_month got busy=%b m=%0d exp busy=1 m=1", busy, month);
        end
        pulse_confirm(7'd5);
        checks++;
        if (busy !== 1'b1 || month !== 4'd5) begin
            failures++; $display("FAIL set_month got busy=%b m=%0d exp busy=1 m=5", busy, month);
        end
        pulse_confirm(7'd120);
        checks++;
        if (busy !== 1'b1 || year !== 7'd0) begin
            failures++; $display("FAIL rej_year got busy=%b y=%0d exp busy=1 y=0", busy, year);
        end
        pulse_confirm(7'd42);
        checks++;
        if (busy !== 1'b0 || month !== 4'd5 || year !== 7'd42) begin
            failures++; $display("FAIL set_done got busy=%b m=%0d y=%0d exp busy=0 m=5 y=42", busy, month, year);
        end
        // confirm while running does nothing
        pulse_confirm(7'd7);
        checks++;
        if (busy !== 1'b0 || month !== 4'd5 || year !== 7'd42) begin
            failures++; $display("FAIL run_confirm got busy=%b m=%0d y=%0d exp busy=0 m=5 y=42", busy, month, year);
        end
    endtask

    task automatic test_pending();
        pulse_set_req();
        pulse_confirm(7'd3);
        for (int i = 0; i < 3; i++) pulse_day_wrap();
        checks++;
        if (month !== 4'd3 || busy !== 1'b1) begin
            failures++; $display("FAIL pend_frozen got m=%0d busy=%b exp m=3 busy=1", month, busy);
        end
        // confirm the year together with a fresh day_wrap
        data = 7'd10; confirm = 1'b1; day_wrap = 1'b1;
        tick();
        confirm = 1'b0; data = '0;
        checks++;
        if (month !== 4'd3 || year !== 7'd10 || busy !== 1'b0) begin
            failures++; $display("FAIL pend_exit got m=%0d y=%0d busy=%b exp m=3 y=10 busy=0", month, year, busy);
        end
        // first RUN cycle also sees a day_wrap: one advance now, one next cycle
        tick();
        day_wrap = 1'b0;
        checks++;
        if (month !== 4'd4) begin failures++; $display("FAIL pend_first got=%0d exp=4", month); end
        tick();
        checks++;
        if (month !== 4'd5) begin failures++; $display("FAIL pend_second got=%0d exp=5", month); end
        tick();
        checks++;
        if (month !== 4'd5) begin failures++; $display("FAIL pend_idle got=%0d exp=5", month); end
    endtask

    task automatic test_setreq_priority();
        // set_req + day_wrap + confirm in RUN: enter SET_MONTH, no advance, confirm ignored
        set_req = 1'b1; day_wrap = 1'b1; confirm = 1'b1; data = 7'd4;
        tick();
        set_req = 1'b0; day_wrap = 1'b0; confirm = 1'b0; data = '0;
        checks++;
        if (busy !== 1'b1 || month !== 4'd5) begin
            failures++; $display("FAIL prio_enter got busy=%b m=%0d exp busy=1 m=5", busy, month);
        end
        pulse_set_req(); // ignored while setting
        pulse_confirm(7'd6);
        pulse_confirm(7'd0);
        checks++;
        if (month !== 4'd6 || year !== 7'd0 || busy !== 1'b0) begin
            failures++; $display("FAIL prio_set got m=%0d y=%0d busy=%b exp m=6 y=0 busy=0", month, year, busy);
        end
        tick();
        checks++;
        if (month !== 4'd7) begin failures++; $display("FAIL prio_pending got=%0d exp=7", month); end
    endtask

    task automatic test_reset_priority();
        pulse_set_req();
        pulse_day_wrap();
        clear = 1'b1; set_req = 1'b1; day_wrap = 1'b1;
        tick();
        clear = 1'b0; set_req = 1'b0; day_wrap = 1'b0;
        checks++;
        if (month !== 4'd1 || year !== 7'd0 || busy !== 1'b0) begin
            failures++; $display("FAIL clr_mid got m=%0d y=%0d busy=%b exp m=1 y=0 busy=0", month, year, busy);
        end
        tick();
        checks++;
        if (month !== 4'd1) begin failures++; $display("FAIL clr_pending got=%0d exp=1", month); end
    endtask

    task automatic test_databus();
        pulse_set_req();
        pulse_confirm(7'd7);
        pulse_confirm(7'd23);
        enable = 1'b0; sel = 1'b0; #1;
        checks++;
        if (databus !== 7'd0) begin failures++; $display("FAIL db_off got=%0d exp=0", databus); end
        enable = 1'b1; #1;
        checks++;
        if (databus !== 7'd7) begin failures++; $display("FAIL db_month got=%0d exp=7", databus); end
        sel = 1'b1; #1;
        checks++;
        if (databus !== 7'd23) begin failures++; $display("FAIL db_year got=%0d exp=23", databus); end
        enable = 1'b0; #1;
        checks++;
        if (databus !== 7'd0) begin failures++; $display("FAIL db_off_sel1 got=%0d exp=0", databus); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clear    = 1'b1;
        day_wrap = 1'b0;
        set_req  = 1'b0;
        confirm  = 1'b0;
        data     = '0;
        sel      = 1'b0;
        enable   = 1'b0;
        #2;
        test_reset();
        test_advance();
        test_year_wrap();
        test_set_rejects();
        test_pending();
        test_setreq_priority();
        test_reset_priority();
        test_databus();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/month_year_counter.md
Name: month_year_counter

Overview:
- Calendar stage directly downstream of the 30-day date counter.
- Consumes the date counter's rollover pulse, fires once per 30->1 wrap.
- Keeps month (1..12) and year (0..YEAR_MAX).
- Provides a two-step set sequence (month, then year) and an enable-gated databus for the display mux.

Parameters:
- YEAR_W, 7: year register width.
- YEAR_MAX, 99: last year value before wrap to 0; must be < 2**YEAR_W.

Ports:
- clk  input  1  system clock, all logic on posedge.
- clear  input  1  synchronous active-high reset.
- day_wrap  input  1  one-cycle pulse from the date counter on its 30->1 rollover.
- set_req  input  1  pulse; starts the set sequence from RUN.
- confirm  input  1  pulse; captures data into the field currently being set.
- data  input  YEAR_W  value to load (month uses data[3:0], upper bits must be 0).
- sel  input  1  databus source: 0 = month, 1 = year.
- enable  input  1  databus output enable.
- month  output  4  current month, 1..12.
- year  output  YEAR_W  current year, 0..YEAR_MAX.
- databus  output  YEAR_W  enable ? (sel ? year : zero-extended month) : 0. Combinational.
- busy  output  1  high when state != RUN.
- year_wrap  output  1  registered one-cycle pulse; marks the year YEAR_MAX->0 wrap.

Behaviour:
- Clocking and reset:
  - One clock (clk).
  - Reset clear is synchronous, active-high, and dominates every other input.
- Values after clear: month=1, year=0, state=RUN, pending=0, year_wrap=0, busy=0. databus follows its equation.
- States:
  - RUN
  - SET_MONTH
  - SET_YEAR
- RUN:
  - An advance is day_wrap or pending.
  - Each advance increments month by one; the new value is visible the cycle after the day_wrap edge.
  - When month==12, an advance sets month=1 and increments year.
  - When year==YEAR_MAX and that wrap occurs, year=0 and year_wrap=1 in the same cycle year shows 0; year_wrap clears next cycle.
  - At most one advance per cycle.
- RUN -> SET_MONTH on set_req:
  - Takes priority over a same-cycle day_wrap.
  - That day_wrap is stored in pending.
- SET_MONTH:
  - Counting is frozen.
  - On confirm with 1 <= data <= 12: month=data[3:0], go to SET_YEAR.
  - On confirm with an invalid data value: value rejected, remain in SET_MONTH, month unchanged.
- SET_YEAR:
  - On confirm with data <= YEAR_MAX: year=data, go to RUN.
  - On confirm with an invalid data value: rejected, remain.
- Pending flag:
  - A day_wrap seen in either SET state sets the 1-bit pending flag. Further day_wraps saturate it; they are not counted.
  - In the first RUN cycle, pending is applied as one advance and pending clears.
  - If day_wrap also arrives that cycle, pending stays 1 and is applied next cycle. This means two advances over two cycles and none are lost.
- set_req in SET_MONTH or SET_YEAR is ignored.
- confirm in RUN is ignored.
- Same-cycle set_req and confirm in RUN: set_req is taken and confirm is ignored.
- clear mid-sequence returns to RUN with reset values; pending is discarded.
- busy = (state != RUN), decoded from the state register.
- No combinational path from day_wrap to month or year; only databus is combinational.

Decomposition:
- Shared package cal_pkg holds:
  - State encoding constants RUN=2'd0, SET_MONTH=2'd1, SET_YEAR=2'd2.
  - MONTH_MIN=1, MONTH_MAX=12.
  - Default YEAR_MAX.
- One natural sub-module, wrap_counter: a parameterised min..max counter with inc, load and wrap-out.
  - Instantiated twice: month 1..12, and year 0..YEAR_MAX with inc = month wrap.
- The FSM, pending flag and databus mux stay in the top.

Test Plan:
- Advance and month wrap: clear, then 11 day_wrap pulses -> month=12, year=0. 12th pulse -> month=1, year=1, year_wrap=0.
- Year wrap: set month=12, year=99 via the set sequence, then one day_wrap -> month=1, year=0, year_wrap=1 for exactly one cycle.
- Set sequence with rejects: set_req; confirm data=13 -> still SET_MONTH, busy=1. confirm data=5 -> SET_YEAR. confirm data=120 -> rejected. confirm data=42 -> RUN, month=5, year=42, busy=0.
- Pending during set:
  - In SET_YEAR, three day_wraps.
  - confirm data=10 on the same cycle as a fresh day_wrap.
  - Expect one advance in the first RUN cycle and one more the next cycle: from month=3 -> 4 then 5.
- Reset priority: clear asserted with set_req and day_wrap in SET_MONTH -> next cycle month=1, year=0, RUN, pending=0. A subsequent idle cycle leaves month at 1.
- Databus:
  - month=7, year=23: enable=0 -> databus=0.
  - enable=1, sel=0 -> 7.
  - sel=1 -> 23, changing in the same cycle as sel.
